fp_sub: RTL and testbench
=========================

Name: fp_sub

Overview:
Pipelined single-precision (fp32) subtractor computing diff = a - b. It is the companion of the accumulator-side fp32 adder and is used by PEs and post-processing to form differences and residuals. Unlike the adder, it handles effective subtraction fully: operand swap, sticky-aware alignment and leading-zero normalisation. It uses a valid/ready handshake with whole-pipeline stall.

Parameters:
ALIGN_W, 27, aligned mantissa width: 24-bit significand + guard, round, sticky.
LAT, 4, pipeline depth in cycles (fixed; informational, checked by bench).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  a/b valid this cycle.
in_ready  out  1  block accepts a/b this cycle.
a  in  32  minuend, IEEE-754 binary32.
b  in  32  subtrahend, IEEE-754 binary32.
out_valid  out  1  diff valid.
out_ready  in  1  consumer accepts diff.
diff  out  32  result, binary32.

Behaviour:
- Reset: synchronous and active-high; sampled on rising clk. All stage-valid bits clear, diff=0, out_valid=0. in_ready=1 after reset since the pipeline is empty. Reset mid-operation drops all in-flight items and produces no outputs.
- Advance: adv = !(out_valid && !out_ready). in_ready = adv. When adv=1 every stage shifts by one. When adv=0 all stage registers hold, and diff/out_valid stay stable.
- Transfer: an input transfers on in_valid && in_ready. An output transfers on out_valid && out_ready. A bubble, when in_valid=0 and adv=1, enters S1 with valid=0.
- Latency: exactly 4 cycles, input accepted at edge N gives out_valid at edge N+4 when out_ready is held at 1. Throughput is 1 per cycle.
- S1 decode:
  - exp==0 means zero; subnormals are flushed to zero.
  - Significand = {1, frac}.
  - The effective sign of b is ~b[31].
  - Compare {exp,frac} magnitudes; larger becomes X, smaller becomes Y.
  - Result sign = sign of X; on equal magnitudes, resolved in S4.
  - eff_sub = sign_a XOR ~sign_b.
- S2 align:
  - d = expX - expY.
  - Y is shifted right by d into ALIGN_W bits; shifted-out bits OR into sticky.
  - If d >= 26, Y becomes sticky-only (1 if Y is nonzero).
  - A zero operand contributes 0.
- S3 compute: 28-bit magnitude = X + Y (eff_sub=0) or X - Y (eff_sub=1). X >= Y, so the result is never negative.
- S4 normalise and pack:
  - Carry out: shift right 1 with sticky preserved, exp+1.
  - Otherwise: count leading zeros lz (0..27), shift left lz, exp - lz.
  - Rounding is round-toward-zero: truncate G/R/S.
  - Exact zero magnitude gives +0 (0x00000000), including x - x and (+0) - (+0).
  - (-0) - (+0) gives 0x80000000.
  - Post-normalise exp <= 0 flushes to signed zero.
  - exp >= 255 gives signed max finite, 0x7F7FFFFF or 0xFF7FFFFF, consistent with RTZ.
- Simultaneous in/out transfer with a full pipeline is legal; there is no bubble.

Optional Feature:
FP_SUB_SPECIAL_EN.
- Defined: exp==255 inputs are decoded as special, and a side flag travels with the item:
  - any NaN input gives 0x7FC00000;
  - inf - inf (same sign) gives 0x7FC00000;
  - inf op finite gives the inf with its effective sign;
  - (+inf) - (-inf) gives 0x7F800000.
  - Latency is unchanged.
- Undefined: exp==255 is treated as an ordinary finite exponent, and any result with exp >= 255 saturates to max finite as above. No NaN or inf is ever produced.

Test Plan:
- 0x40400000 - 0x3F800000 (3.0-1.0) with out_ready=1: diff=0x40000000 and out_valid exactly 4 cycles after acceptance. Also 0x3F800000 - 0xBF800000 gives 0x40000000.
- 0x3F800000 - 0x3F800000 gives 0x00000000. 0x3F800000 - 0x3F800001 gives 0xB4000000, exercising the 23-bit left normalise.
- 0x7F7FFFFF - 0xFF7FFFFF gives 0x7F7FFFFF (overflow saturates). 0x00800000 - 0x00800001 gives 0x80000000 (underflow flush).
- Stream 6 back-to-back inputs, with out_ready=0 for 3 cycles after the first out_valid:
  - in_ready low during the stall;
  - diff held stable while stalled;
  - all 6 results in order, none lost or duplicated.
- Assert rst with 3 items in flight: out_valid=0 the next cycle, no stale output ever appears, and a fresh input gives its result 4 cycles later.
- With FP_SUB_SPECIAL_EN defined:
  - 0x7FC00000 - 0x3F800000 gives 0x7FC00000;
  - 0x7F800000 - 0x7F800000 gives 0x7FC00000;
  - 0x7F800000 - 0xFF800000 gives 0x7F800000.

Source files
------------

// File: rtl/fp_sub.sv
// fp_sub: pipelined fp32 subtractor diff = a - b, round-toward-zero, subnormals flushed to zero.
// Define FP_SUB_SPECIAL_EN to decode exp==255 inputs as NaN/infinity; otherwise they are ordinary finite values.
module fp_sub #(
    parameter int ALIGN_W = 27,
    parameter int LAT     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] diff
);
    logic               w_adv;
    logic [LAT:0]       r_vld;
    logic               w_za, w_zb, w_sbe, w_swap;
    logic [30:0]        w_ka, w_kb;
    logic [23:0]        w_ma, w_mb;
    logic               w_spc;
    logic [31:0]        w_sval;
    logic               r_s1_sx, r_s1_eff, r_s1_spc;
    logic [7:0]         r_s1_ex, r_s1_ey;
    logic [23:0]        r_s1_mx, r_s1_my;
    logic [31:0]        r_s1_sv;
    logic [7:0]         w_d;
    logic [ALIGN_W-1:0] w_yx, w_ysh, w_yal;
    logic               w_ylost;
    logic               r_s2_sx, r_s2_eff, r_s2_spc;
    logic [7:0]         r_s2_ex;
    logic [ALIGN_W-1:0] r_s2_mx, r_s2_my;
    logic [31:0]        r_s2_sv;
    logic               r_s3_sx, r_s3_eff, r_s3_spc;
    logic [7:0]         r_s3_ex;
    logic [ALIGN_W:0]   r_s3_mag;
    logic [31:0]        r_s3_sv;
    logic [4:0]         w_lz;
    logic               w_cy, w_mz;
    logic [9:0]         w_e;
    logic [22:0]        w_frac;
    logic               r_s4_sign, r_s4_zero, r_s4_sat, r_s4_spc;
    logic [7:0]         r_s4_e;
    logic [22:0]        r_s4_frac;
    logic [31:0]        r_s4_sv;

    // The whole pipeline moves unless a finished result is waiting on the consumer.
    assign w_adv     = !(out_valid && !out_ready);
    assign in_ready  = w_adv;
    assign out_valid = r_vld[LAT];

    // Decode: flush subnormals, negate b, order operands so X has the larger magnitude.
    assign w_za   = a[30:23] == 8'd0;
    assign w_zb   = b[30:23] == 8'd0;
    assign w_ka   = w_za ? 31'd0 : a[30:0];
    assign w_kb   = w_zb ? 31'd0 : b[30:0];
    assign w_ma   = w_za ? 24'd0 : {1'b1, a[22:0]};
    assign w_mb   = w_zb ? 24'd0 : {1'b1, b[22:0]};
    assign w_sbe  = ~b[31];
    assign w_swap = w_kb > w_ka;

`ifdef FP_SUB_SPECIAL_EN
    logic w_nan, w_ia, w_ib;
    assign w_nan  = (&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0]);
    assign w_ia   = &a[30:23] && ~|a[22:0];
    assign w_ib   = &b[30:23] && ~|b[22:0];
    assign w_spc  = &a[30:23] || &b[30:23];
    assign w_sval = (w_nan || (w_ia && w_ib && (a[31] ^ w_sbe))) ? 32'h7FC00000 :
                    w_ia ? {a[31], 31'h7F800000} : {w_sbe, 31'h7F800000};
`else
    assign w_spc  = 1'b0;
    assign w_sval = 32'd0;
`endif

    // Stage valid bits; reset drops every in-flight item.
    always_ff @(posedge clk) begin
        if (rst)
            r_vld <= '0;
        else if (w_adv)
            r_vld <= {r_vld[LAT-1:0], in_valid};
    end

    // S1: register the ordered operands and the effective operation.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1_sx  <= w_swap ? w_sbe : a[31];
            r_s1_eff <= a[31] ^ w_sbe;
            r_s1_ex  <= w_swap ? b[30:23] : a[30:23];
            r_s1_ey  <= w_swap ? a[30:23] : b[30:23];
            r_s1_mx  <= w_swap ? w_mb : w_ma;
            r_s1_my  <= w_swap ? w_ma : w_mb;
            r_s1_spc <= w_spc;
            r_s1_sv  <= w_sval;
        end
    end

    // Align Y to X; bits shifted past the sticky position are OR-ed into it.
    assign w_d     = r_s1_ex - r_s1_ey;
    assign w_yx    = {r_s1_my, 3'b000};
    assign w_ysh   = w_yx >> w_d;
    assign w_ylost = |(w_yx & ~({ALIGN_W{1'b1}} << w_d));
    assign w_yal   = (w_d >= 8'd26) ? {{(ALIGN_W-1){1'b0}}, |r_s1_my} :
                     {w_ysh[ALIGN_W-1:1], w_ysh[0] | w_ylost};

    // S2: register the aligned significands.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s2_sx  <= r_s1_sx;
            r_s2_eff <= r_s1_eff;
            r_s2_ex  <= r_s1_ex;
            r_s2_mx  <= {r_s1_mx, 3'b000};
            r_s2_my  <= w_yal;
            r_s2_spc <= r_s1_spc;
            r_s2_sv  <= r_s1_sv;
        end
    end

    // S3: magnitude add or subtract; X >= Y keeps the difference non-negative.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s3_sx  <= r_s2_sx;
            r_s3_eff <= r_s2_eff;
            r_s3_ex  <= r_s2_ex;
            r_s3_mag <= r_s2_eff ? {1'b0, r_s2_mx} - {1'b0, r_s2_my} : {1'b0, r_s2_mx} + {1'b0, r_s2_my};
            r_s3_spc <= r_s2_spc;
            r_s3_sv  <= r_s2_sv;
        end
    end

    // Leading-zero count below the carry bit; the highest set bit wins.
    always_comb begin
        w_lz = 5'd27;
        for (int i = 0; i < ALIGN_W; i++)
            if (r_s3_mag[i]) w_lz = 5'(ALIGN_W - 1 - i);
    end

    // Normalise: a carry shifts right once, otherwise shift left by lz; G/R/S are truncated.
    assign w_cy   = r_s3_mag[ALIGN_W];
    assign w_mz   = r_s3_mag == '0;
    assign w_e    = w_cy ? {2'b00, r_s3_ex} + 10'd1 : {2'b00, r_s3_ex} - {5'd0, w_lz};
    assign w_frac = w_cy ? r_s3_mag[ALIGN_W-1:4] : 23'((r_s3_mag[ALIGN_W-2:0] << w_lz) >> 3);

    // S4: register normalised fields with underflow/overflow decisions.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s4_sign <= w_mz ? (r_s3_sx & ~r_s3_eff) : r_s3_sx;
            r_s4_zero <= w_mz || w_e[9] || (w_e == 10'd0);
            r_s4_sat  <= !w_e[9] && (w_e >= 10'd255);
            r_s4_e    <= w_e[7:0];
            r_s4_frac <= w_frac;
            r_s4_spc  <= r_s3_spc;
            r_s4_sv   <= r_s3_sv;
        end
    end

    // Output: pack the result, saturating to max finite as round-toward-zero requires.
    always_ff @(posedge clk) begin
        if (rst)
            diff <= 32'd0;
        else if (w_adv)
            diff <= r_s4_spc  ? r_s4_sv :
                    r_s4_zero ? {r_s4_sign, 31'd0} :
                    r_s4_sat  ? {r_s4_sign, 31'h7F7FFFFF} :
                    {r_s4_sign, r_s4_e, r_s4_frac};
    end
endmodule

// File: tb/tb_fp_sub.sv
// tb_fp_sub: directed and random checks of fp_sub against an exact-arithmetic reference.
module tb_fp_sub;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, acc;
    logic [31:0] a, b, diff, held;
    logic [31:0] q[$];
    logic [31:0] sa_in[6], sb_in[6];
    int          n_chk = 0, n_err = 0, n_out = 0;

    always #5 clk = ~clk;

    fp_sub dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .diff(diff)
    );

    // Exact reference: integer significands aligned without loss, then truncated.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
        logic sa, sb, sub, sg;
        logic [30:0] ka, kb, kh, r;
        logic [31:0] sat;
        int eh, el, d, p, e;
        longint unsigned mh, ml, s, m;
        sa = x[31]; sb = ~y[31]; sub = sa ^ sb;
`ifdef FP_SUB_SPECIAL_EN
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
            if ((x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0)) return 32'h7FC00000;
            if (x[30:23] == 8'hFF && y[30:23] == 8'hFF) return sub ? 32'h7FC00000 : {sa, 31'h7F800000};
            return (x[30:23] == 8'hFF) ? {sa, 31'h7F800000} : {sb, 31'h7F800000};
        end
`endif
        ka = (x[30:23] == 0) ? 31'd0 : x[30:0];
        kb = (y[30:23] == 0) ? 31'd0 : y[30:0];
        if (ka == 0 && kb == 0) return {sa & sb, 31'd0};
        if (ka >= kb) begin
            sg = sa; kh = ka; eh = int'(ka[30:23]); el = int'(kb[30:23]);
            mh = longint'({1'b1, ka[22:0]}); ml = (kb == 0) ? 0 : longint'({1'b1, kb[22:0]});
        end else begin
            sg = sb; kh = kb; eh = int'(kb[30:23]); el = int'(ka[30:23]);
            mh = longint'({1'b1, kb[22:0]}); ml = (ka == 0) ? 0 : longint'({1'b1, ka[22:0]});
        end
        sat = {sg, 31'h7F7FFFFF};
        if (ml == 0) return (eh == 255) ? sat : {sg, kh};
        d = eh - el;
        if (d > 38) begin
            r = sub ? kh - 31'd1 : kh;
            return (r[30:23] == 0) ? {sg, 31'd0} : (r[30:23] == 8'hFF) ? sat : {sg, r};
        end
        s = sub ? (mh << d) - ml : (mh << d) + ml;
        if (s == 0) return 32'd0;
        p = 63;
        while (!s[p]) p--;
        e = el + p - 23;
        if (e <= 0) return {sg, 31'd0};
        if (e >= 255) return sat;
        m = (p >= 23) ? s >> (p - 23) : s << (23 - p);
        return {sg, e[7:0], m[22:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, score the transfers of the coming edge, then step past it.
    task automatic step(input logic v, input logic [31:0] x, input logic [31:0] y, input logic ordy,
                        input logic ue, input logic [31:0] ev);
        in_valid = v; a = x; b = y; out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            check("out_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) check("diff", diff, q.pop_front());
            n_out++;
        end
        if (acc) q.push_back(ue ? ev : model(x, y));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ev);
        step(1'b1, x, y, 1'b1, 1'b1, ev);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    endtask

    initial begin
        int idx, stall, n0, md;
        logic [31:0] x, y, rr;
        logic [7:0] ee;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        idle(2);
        rst = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_diff", diff, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        send(32'h40400000, 32'h3F800000, 32'h40000000);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) idle(1);
            check("latency_out_valid", 32'(out_valid), 32'(k == 4));
        end
        send(32'h3F800000, 32'hBF800000, 32'h40000000);
        send(32'h3F800000, 32'h3F800000, 32'h00000000);
        send(32'h3F800000, 32'h3F800001, 32'hB4000000);
        send(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F7FFFFF);
        send(32'h00800000, 32'h00800001, 32'h80000000);
        send(32'h80000000, 32'h00000000, 32'h80000000);
        send(32'h00000000, 32'h00000000, 32'h00000000);
        send(32'h00000001, 32'h00000000, 32'h00000000);
`ifdef FP_SUB_SPECIAL_EN
        send(32'h7FC00000, 32'h3F800000, 32'h7FC00000);
        send(32'h7F800000, 32'h7F800000, 32'h7FC00000);
        send(32'h7F800000, 32'hFF800000, 32'h7F800000);
`endif
        idle(6);

        for (int k = 0; k < 6; k++) begin sa_in[k] = $urandom; sb_in[k] = $urandom; end
        idx = 0; stall = -1; n0 = n_out;
        for (int c = 0; c < 24; c++) begin
            if (stall > 0) begin
                step(idx < 6, sa_in[idx % 6], sb_in[idx % 6], 1'b0, 1'b0, 32'd0);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_diff_held", diff, held);
                stall--;
            end else begin
                step(idx < 6, sa_in[idx % 6], sb_in[idx % 6], 1'b1, 1'b0, 32'd0);
                if (stall < 0 && out_valid) begin stall = 3; held = diff; end
            end
            if (acc) idx++;
        end
        check("stream_outputs", 32'(n_out - n0), 32'd6);
        check("stream_drained", 32'(q.size()), 32'd0);

        for (int k = 0; k < 3; k++) step(1'b1, $urandom, $urandom, 1'b1, 1'b0, 32'd0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        q.delete();
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_diff", diff, 32'd0);
        send(32'h3F800000, 32'hBF800000, 32'h40000000);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) idle(1);
            check("post_reset_latency", 32'(out_valid), 32'(k == 4));
        end
        idle(6);

        for (int c = 0; c < 600; c++) begin
            x = $urandom; rr = $urandom; md = int'($urandom_range(0, 3));
            ee = x[30:23] - 8'($urandom_range(0, 40));
            y = (md == 0) ? rr :
                (md == 1) ? x ^ (rr & 32'h000000FF) :
                (md == 2) ? {rr[31], x[30:0] + (rr & 32'h018000FF)} :
                {rr[31], ee, rr[22:0]};
            step($urandom_range(0, 9) < 8, x, y, $urandom_range(0, 3) != 0, 1'b0, 32'd0);
        end
        idle(10);
        check("final_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
